// File: rtl/axi4l_if.sv
// AXI4-Lite channel bundle (32-bit address/data) carrying its own clock and reset.
interface axi4l_if (
   input logic aclk,
   input logic aresetn
);
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      input  aclk, aresetn,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  aclk, aresetn,
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/ibex_data_axi4l_bridge.sv
// Ibex data-side req/gnt/rvalid to single-outstanding AXI4-Lite master bridge.
// Define AXI4L_BRIDGE_B2B_EN to allow a new grant in DONE (3-cycle throughput).
module ibex_data_axi4l_bridge (
   axi4l_if.master     axi,
   input  logic        data_req,
   output logic        data_gnt,
   input  logic        data_we,
   input  logic [3:0]  data_be,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   output logic        data_err
);
   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        arvalid_q, arvalid_d;
   logic        bready_q, bready_d;
   logic        rready_q, rready_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        gnt_state;
   logic        unused_resp;

   assign unused_resp = axi.bresp[0] ^ axi.rresp[0];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      // Each valid clears on its own handshake, so AW and W complete independently.
      awvalid_d = awvalid_q & ~axi.awready;
      wvalid_d  = wvalid_q & ~axi.wready;
      arvalid_d = arvalid_q & ~axi.arready;
      bready_d  = bready_q;
      rready_d  = rready_q;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;

`ifdef AXI4L_BRIDGE_B2B_EN
      gnt_state = (state_q == IDLE) || (state_q == DONE);
`else
      gnt_state = (state_q == IDLE);
`endif
      data_gnt = axi.aresetn & data_req & gnt_state;

      unique case (state_q)
         IDLE: ;
         WADDR: begin
            if (!awvalid_d && !wvalid_d) begin
               state_d  = WRESP;
               bready_d = 1'b1;
            end
         end
         WRESP: begin
            if (bready_q && axi.bvalid) begin
               bready_d = 1'b0;
               rdata_d  = '0;
               err_d    = axi.bresp[1];
               rvalid_d = 1'b1;
               state_d  = DONE;
            end
         end
         RADDR: begin
            if (arvalid_q && axi.arready) begin
               state_d  = RRESP;
               rready_d = 1'b1;
            end
         end
         RRESP: begin
            if (rready_q && axi.rvalid) begin
               rready_d = 1'b0;
               rdata_d  = axi.rdata;
               err_d    = axi.rresp[1];
               rvalid_d = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A grant overrides the DONE->IDLE step when back-to-back is enabled.
      if (data_gnt) begin
         addr_d    = {data_addr[31:2], 2'b00};
         wdata_d   = data_wdata;
         be_d      = data_be;
         awvalid_d = data_we;
         wvalid_d  = data_we;
         arvalid_d = ~data_we;
         state_d   = data_we ? WADDR : RADDR;
      end
   end

   always_ff @(posedge axi.aclk or negedge axi.aresetn) begin
      if (!axi.aresetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         bready_q  <= bready_d;
         rready_q  <= rready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign axi.awaddr  = addr_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = be_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.araddr  = addr_q;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   assign data_rvalid = rvalid_q;
   assign data_rdata  = rdata_q;
   assign data_err    = err_q;
endmodule

// File: tb/tb_ibex_data_axi4l_bridge.sv
// Scoreboard bench for ibex_data_axi4l_bridge with a stallable AXI4-Lite slave model.
module tb_ibex_data_axi4l_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi4l_if axi (.aclk(clk), .aresetn(rst_n));

   logic        data_req, data_gnt, data_we, data_rvalid, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;

   ibex_data_axi4l_bridge dut (
      .axi         (axi),
      .data_req    (data_req),
      .data_gnt    (data_gnt),
      .data_we     (data_we),
      .data_be     (data_be),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata),
      .data_err    (data_err)
   );

`ifdef AXI4L_BRIDGE_B2B_EN
   localparam int GNT_SPACING = 3;
`else
   localparam int GNT_SPACING = 4;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
   typedef struct { logic [31:0] rdata; logic [1:0] resp; } slv_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; } w_t;
   rsp_t        rsp_q[$];
   slv_t        slv_q[$];
   w_t          w_q[$];
   logic [31:0] aw_q[$];
   logic [31:0] ar_q[$];

   // Slave model: each ready rises after *_stall cycles of valid; response one cycle later.
   int          aw_stall = 0, w_stall = 0, ar_stall = 0;
   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_got, w_got, r_hold = 1'b0;
   logic        s_bvalid, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   logic        aw_hs, w_hs, ar_hs;
   slv_t        s;

   assign axi.awready = (aw_cnt >= aw_stall);
   assign axi.wready  = (w_cnt >= w_stall);
   assign axi.arready = (ar_cnt >= ar_stall);
   assign axi.bvalid  = s_bvalid;
   assign axi.bresp   = s_bresp;
   assign axi.rvalid  = s_rvalid;
   assign axi.rresp   = s_rresp;
   assign axi.rdata   = s_rdata;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         s_bvalid <= 1'b0; s_rvalid <= 1'b0;
         s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
      end else begin
         aw_hs = axi.awvalid && axi.awready;
         w_hs  = axi.wvalid && axi.wready;
         ar_hs = axi.arvalid && axi.arready;
         if (aw_hs) aw_cnt <= 0; else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
         if (w_hs) w_cnt <= 0; else if (axi.wvalid) w_cnt <= w_cnt + 1;
         if (ar_hs) ar_cnt <= 0; else if (axi.arvalid) ar_cnt <= ar_cnt + 1;
         if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
         if (s_rvalid && axi.rready) s_rvalid <= 1'b0;
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            if (slv_q.size() > 0) begin
               s = slv_q.pop_front();
               s_bvalid <= 1'b1;
               s_bresp  <= s.resp;
            end
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs) w_got <= 1'b1;
         end
         if (ar_hs && slv_q.size() > 0) begin
            s = slv_q.pop_front();
            if (!r_hold) begin
               s_rvalid <= 1'b1;
               s_rdata  <= s.rdata;
               s_rresp  <= s.resp;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a response or handshake.
   logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_rvalid) begin
            if (rsp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_rvalid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
               rsp_t e;
               e = rsp_q.pop_front();
               check("data_rdata", data_rdata, e.rdata);
               check("data_err", 32'(data_err), 32'(e.err));
               check("rvalid_cycle", cyc, e.cyc);
            end
         end
         if (aw_pend) check("awvalid_stable", 32'(axi.awvalid), 32'd1);
         if (w_pend) check("wvalid_stable", 32'(axi.wvalid), 32'd1);
         if (ar_pend) check("arvalid_stable", 32'(axi.arvalid), 32'd1);
         if (axi.awvalid && axi.awready && aw_q.size() > 0)
            check("awaddr", axi.awaddr, aw_q.pop_front());
         if (axi.wvalid && axi.wready && w_q.size() > 0) begin
            w_t ew;
            ew = w_q.pop_front();
            check("wdata", axi.wdata, ew.data);
            check("wstrb", 32'(axi.wstrb), 32'(ew.strb));
         end
         if (axi.arvalid && axi.arready && ar_q.size() > 0)
            check("araddr", axi.araddr, ar_q.pop_front());
         aw_pend = axi.awvalid && !axi.awready;
         w_pend  = axi.wvalid && !axi.wready;
         ar_pend = axi.arvalid && !axi.arready;
      end else begin
         aw_pend = 1'b0;
         w_pend  = 1'b0;
         ar_pend = 1'b0;
      end
   end

   task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_addr,
                        input logic [31:0] s_data, input logic [1:0] s_resp,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int extra, input bit expect_rsp, output int g);
      data_req   = 1'b1;
      data_we    = we;
      data_be    = be;
      data_addr  = addr;
      data_wdata = wdata;
      g = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (data_gnt) begin
            g = cyc;
            break;
         end
      end
      if (g < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL grant_timeout: got no grant expected grant within 50 cycles");
      end else begin
         slv_q.push_back('{rdata: s_data, resp: s_resp});
         if (we) begin
            aw_q.push_back(exp_addr);
            w_q.push_back('{data: wdata, strb: be});
         end else begin
            ar_q.push_back(exp_addr);
         end
         if (expect_rsp) rsp_q.push_back('{rdata: exp_rdata, err: exp_err, cyc: g + 3 + extra});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (rsp_q.size() == 0) break;
         @(posedge clk);
      end
      check("drain_pending", rsp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int g, g0, g1, g2;
      data_req = 1'b1; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(data_gnt), 32'd0);
      check("rst_rvalid", 32'(data_rvalid), 32'd0);
      check("rst_rdata", data_rdata, 32'd0);
      check("rst_err", 32'(data_err), 32'd0);
      check("rst_valids", {29'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
      check("rst_readies", {30'd0, axi.bready, axi.rready}, 32'd0);
      data_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(1'b1, 4'hF, 32'h14, 32'hDEADBEEF, 32'h14, 32'h0, 2'b00, 32'h0, 1'b0, 0, 1'b1, g);
      data_req = 1'b0;
      drain();

      issue(1'b0, 4'h0, 32'h16, 32'h0, 32'h14, 32'h12345678, 2'b00, 32'h12345678, 1'b0, 0, 1'b1, g);
      data_req = 1'b0;
      drain();

      aw_stall = 2;
      issue(1'b1, 4'b0011, 32'h20, 32'hA5A50F0F, 32'h20, 32'h0, 2'b00, 32'h0, 1'b0, 2, 1'b1, g);
      data_req = 1'b0;
      @(negedge clk);
      check("stall_c1_wvalid", 32'(axi.wvalid), 32'd1);
      @(negedge clk);
      check("stall_c2_wvalid", 32'(axi.wvalid), 32'd0);
      check("stall_c2_awvalid", 32'(axi.awvalid), 32'd1);
      drain();
      aw_stall = 0;

      issue(1'b0, 4'hF, 32'h100, 32'h0, 32'h100, 32'hCAFEF00D, 2'b10, 32'hCAFEF00D, 1'b1, 0, 1'b1, g);
      data_req = 1'b0;
      drain();
      issue(1'b0, 4'hF, 32'h107, 32'h0, 32'h104, 32'h0BADF00D, 2'b00, 32'h0BADF00D, 1'b0, 0, 1'b1, g);
      data_req = 1'b0;
      drain();

      w_stall = 1;
      issue(1'b1, 4'b1000, 32'h8, 32'h11223344, 32'h8, 32'h0, 2'b10, 32'h0, 1'b1, 1, 1'b1, g);
      data_req = 1'b0;
      drain();
      w_stall = 0;
      ar_stall = 3;
      issue(1'b0, 4'h0, 32'h31, 32'h0, 32'h30, 32'h87654321, 2'b00, 32'h87654321, 1'b0, 3, 1'b1, g);
      data_req = 1'b0;
      drain();
      ar_stall = 0;

      r_hold = 1'b1;
      issue(1'b0, 4'h0, 32'h40, 32'h0, 32'h40, 32'hFFFFFFFF, 2'b00, 32'h0, 1'b0, 0, 1'b0, g);
      data_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rresp_rready", 32'(axi.rready), 32'd1);
      #1 rst_n = 1'b0;
      data_req = 1'b1;
      #1;
      check("midrst_gnt", 32'(data_gnt), 32'd0);
      check("midrst_valids", {29'd0, axi.awvalid, axi.wvalid, axi.arvalid}, 32'd0);
      check("midrst_readies", {30'd0, axi.bready, axi.rready}, 32'd0);
      data_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("midrst_rvalid", 32'(data_rvalid), 32'd0);
      end
      rst_n = 1'b1;
      r_hold = 1'b0;
      @(posedge clk); #1;
      issue(1'b0, 4'h0, 32'h44, 32'h0, 32'h44, 32'h55AA55AA, 2'b00, 32'h55AA55AA, 1'b0, 0, 1'b1, g);
      data_req = 1'b0;
      drain();

      issue(1'b0, 4'h0, 32'h200, 32'h0, 32'h200, 32'h1, 2'b00, 32'h1, 1'b0, 0, 1'b1, g0);
      issue(1'b0, 4'h0, 32'h204, 32'h0, 32'h204, 32'h2, 2'b00, 32'h2, 1'b0, 0, 1'b1, g1);
      issue(1'b0, 4'h0, 32'h208, 32'h0, 32'h208, 32'h3, 2'b00, 32'h3, 1'b0, 0, 1'b1, g2);
      data_req = 1'b0;
      check("gnt_spacing_1", g1 - g0, GNT_SPACING);
      check("gnt_spacing_2", g2 - g1, GNT_SPACING);
      drain();

      check("queues_empty", aw_q.size() + w_q.size() + ar_q.size() + slv_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
